// File: rtl/reg_file.sv
// RV32 integer register file: x0 reads as zero, two combinational read ports,
// one synchronous write port with a same-cycle write-through bypass.
module reg_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rs1_addr,
    output logic [DATA_W-1:0] rs1_data,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [DATA_W-1:0] rs2_data,
    input  logic              we,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data
);

    localparam int DEPTH = 2 ** ADDR_W;

    // Only x1..x(DEPTH-1) have storage; x0 is synthesised as a constant.
    logic [DATA_W-1:0] regs_q [1:DEPTH-1];
    logic [DATA_W-1:0] regs_d [1:DEPTH-1];
    logic              wrActive;

    assign wrActive = rst_n && we && (rd_addr != '0);

    always_comb begin
        regs_d = regs_q;
        for (int i = 1; i < DEPTH; i++) begin
            if (!rst_n) begin
                regs_d[i] = '0;
            end else if (we && (rd_addr == ADDR_W'(i))) begin
                regs_d[i] = rd_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        regs_q <= regs_d;
    end

    // Array lookup first, then the bypass overrides so decode sees the value being written back.
    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        for (int i = 1; i < DEPTH; i++) begin
            if (rs1_addr == ADDR_W'(i)) rs1_data = regs_q[i];
            if (rs2_addr == ADDR_W'(i)) rs2_data = regs_q[i];
        end
        if (wrActive && (rd_addr == rs1_addr)) rs1_data = rd_data;
        if (wrActive && (rd_addr == rs2_addr)) rs2_data = rd_data;
    end

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file: reset, basic access, x0,
// bypass, reset priority, back-to-back writes and a full sweep.
module tb_reg_file;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rs1_addr;
    logic [31:0] rs1_data;
    logic [4:0]  rs2_addr;
    logic [31:0] rs2_data;
    logic        we;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;

    int checkCount;
    int passCount;

    reg_file #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rs1_addr (rs1_addr),
        .rs1_data (rs1_data),
        .rs2_addr (rs2_addr),
        .rs2_data (rs2_data),
        .we       (we),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are sampled 2ns later.
    task automatic drive(input logic r, input logic w, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [4:0] a1, input logic [4:0] a2);
        @(negedge clk);
        rst_n    = r;
        we       = w;
        rd_addr  = wa;
        rd_data  = wd;
        rs1_addr = a1;
        rs2_addr = a2;
        #2;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        repeat (10) @(posedge clk);
        for (int a = 0; a < 32; a++) begin
            drive(1'b1, 1'b0, 5'd0, 32'h0, 5'(a), 5'(31 - a));
            checkCount++;
            if (rs1_data !== 32'h0) $display("[TB] FAIL reset_rs1 addr=%0d got=%h exp=%h", a, rs1_data, 32'h0);
            else passCount++;
            checkCount++;
            if (rs2_data !== 32'h0) $display("[TB] FAIL reset_rs2 addr=%0d got=%h exp=%h", 31 - a, rs2_data, 32'h0);
            else passCount++;
        end
    endtask

    task automatic test_basic();
        drive(1'b1, 1'b1, 5'd1, 32'h12345678, 5'd0, 5'd0);
        drive(1'b1, 1'b1, 5'd2, 32'h87654321, 5'd0, 5'd0);
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd1, 5'd2);
        checkCount++;
        if (rs1_data !== 32'h12345678) $display("[TB] FAIL basic_x1 got=%h exp=%h", rs1_data, 32'h12345678);
        else passCount++;
        checkCount++;
        if (rs2_data !== 32'h87654321) $display("[TB] FAIL basic_x2 got=%h exp=%h", rs2_data, 32'h87654321);
        else passCount++;
    endtask

    task automatic test_x0();
        drive(1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
        checkCount++;
        if (rs1_data !== 32'h0) $display("[TB] FAIL x0_same_cycle got=%h exp=%h", rs1_data, 32'h0);
        else passCount++;
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd1);
        checkCount++;
        if (rs1_data !== 32'h0) $display("[TB] FAIL x0_after got=%h exp=%h", rs1_data, 32'h0);
        else passCount++;
        checkCount++;
        if (rs2_data !== 32'h12345678) $display("[TB] FAIL x0_keeps_x1 got=%h exp=%h", rs2_data, 32'h12345678);
        else passCount++;
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd2, 5'd0);
        checkCount++;
        if (rs1_data !== 32'h87654321) $display("[TB] FAIL x0_keeps_x2 got=%h exp=%h", rs1_data, 32'h87654321);
        else passCount++;
    endtask

    task automatic test_bypass();
        drive(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5);
        checkCount++;
        if (rs1_data !== 32'hDEADBEEF) $display("[TB] FAIL bypass_rs1 got=%h exp=%h", rs1_data, 32'hDEADBEEF);
        else passCount++;
        checkCount++;
        if (rs2_data !== 32'hDEADBEEF) $display("[TB] FAIL bypass_rs2 got=%h exp=%h", rs2_data, 32'hDEADBEEF);
        else passCount++;
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
        checkCount++;
        if (rs1_data !== 32'hDEADBEEF) $display("[TB] FAIL bypass_commit_rs1 got=%h exp=%h", rs1_data, 32'hDEADBEEF);
        else passCount++;
        checkCount++;
        if (rs2_data !== 32'hDEADBEEF) $display("[TB] FAIL bypass_commit_rs2 got=%h exp=%h", rs2_data, 32'hDEADBEEF);
        else passCount++;
        // Bypass hits only the port whose address matches the write.
        drive(1'b1, 1'b1, 5'd6, 32'h0BADF00D, 5'd5, 5'd6);
        checkCount++;
        if (rs1_data !== 32'hDEADBEEF) $display("[TB] FAIL bypass_indep_rs1 got=%h exp=%h", rs1_data, 32'hDEADBEEF);
        else passCount++;
        checkCount++;
        if (rs2_data !== 32'h0BADF00D) $display("[TB] FAIL bypass_indep_rs2 got=%h exp=%h", rs2_data, 32'h0BADF00D);
        else passCount++;
    endtask

    task automatic test_reset_priority();
        drive(1'b1, 1'b1, 5'd3, 32'hA5A5A5A5, 5'd0, 5'd0);
        drive(1'b0, 1'b1, 5'd3, 32'h5A5A5A5A, 5'd3, 5'd1);
        checkCount++;
        if (rs1_data !== 32'hA5A5A5A5) $display("[TB] FAIL rstpri_no_bypass got=%h exp=%h", rs1_data, 32'hA5A5A5A5);
        else passCount++;
        checkCount++;
        if (rs2_data !== 32'h12345678) $display("[TB] FAIL rstpri_pre_x1 got=%h exp=%h", rs2_data, 32'h12345678);
        else passCount++;
        for (int a = 0; a < 32; a++) begin
            drive(1'b1, 1'b0, 5'd0, 32'h0, 5'(a), 5'(a));
            checkCount++;
            if (rs1_data !== 32'h0) $display("[TB] FAIL rstpri_rs1 addr=%0d got=%h exp=%h", a, rs1_data, 32'h0);
            else passCount++;
            checkCount++;
            if (rs2_data !== 32'h0) $display("[TB] FAIL rstpri_rs2 addr=%0d got=%h exp=%h", a, rs2_data, 32'h0);
            else passCount++;
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 1'b1, 5'd7, 32'h00000111, 5'd0, 5'd0);
        drive(1'b1, 1'b1, 5'd7, 32'h00000222, 5'd0, 5'd0);
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd7, 5'd0);
        checkCount++;
        if (rs1_data !== 32'h00000222) $display("[TB] FAIL b2b_last_wins got=%h exp=%h", rs1_data, 32'h00000222);
        else passCount++;
    endtask

    task automatic test_sweep();
        logic [31:0] exp1;
        logic [31:0] exp2;
        for (int i = 1; i < 32; i++) begin
            drive(1'b1, 1'b1, 5'(i), 32'h01010101 * 32'(i), 5'd0, 5'd0);
        end
        for (int i = 1; i < 32; i++) begin
            drive(1'b1, 1'b0, 5'd0, 32'h0, 5'(i), 5'(32 - i));
            exp1 = 32'h01010101 * 32'(i);
            exp2 = 32'h01010101 * 32'(32 - i);
            checkCount++;
            if (rs1_data !== exp1) $display("[TB] FAIL sweep_rs1 addr=%0d got=%h exp=%h", i, rs1_data, exp1);
            else passCount++;
            checkCount++;
            if (rs2_data !== exp2) $display("[TB] FAIL sweep_rs2 addr=%0d got=%h exp=%h", 32 - i, rs2_data, exp2);
            else passCount++;
        end
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        checkCount++;
        if (rs1_data !== 32'h0) $display("[TB] FAIL sweep_x0_rs1 got=%h exp=%h", rs1_data, 32'h0);
        else passCount++;
        checkCount++;
        if (rs2_data !== 32'h0) $display("[TB] FAIL sweep_x0_rs2 got=%h exp=%h", rs2_data, 32'h0);
        else passCount++;
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        rst_n      = 1'b0;
        we         = 1'b0;
        rd_addr    = '0;
        rd_data    = '0;
        rs1_addr   = '0;
        rs2_addr   = '0;
        test_reset();
        test_basic();
        test_x0();
        test_bypass();
        test_reset_priority();
        test_back_to_back();
        test_sweep();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
